// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_pkg
// Description : Shared definitions for the two-requester data-memory arbiter.
//               These are the RISC-V load/store width codes (func3), the
//               arbiter FSM state type, and helpers for byte enables, load
//               extension and command legality.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    localparam logic [2:0] c_F3_B  = 3'd0;   // sb / lb
    localparam logic [2:0] c_F3_H  = 3'd1;   // sh / lh
    localparam logic [2:0] c_F3_W  = 3'd2;   // sw / lw
    localparam logic [2:0] c_F3_BU = 3'd4;   // lbu
    localparam logic [2:0] c_F3_HU = 3'd5;   // lhu

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    function automatic logic is_half(input logic [2:0] f3);
        return (f3 == c_F3_H) || (f3 == c_F3_HU);
    endfunction

    // Stores only exist for the signed width codes. lbu/lhu are load-only.
    function automatic logic f3_legal(input logic [2:0] f3, input logic we);
        case (f3)
            c_F3_B, c_F3_H, c_F3_W: return 1'b1;
            c_F3_BU, c_F3_HU:       return ~we;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            c_F3_B, c_F3_BU: return 4'b0001 << off;
            c_F3_H, c_F3_HU: return 4'b0011 << off;
            default:         return 4'b1111;
        endcase
    endfunction

    // v is the memory word already shifted so the addressed byte sits in [7:0].
    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] v);
        case (f3)
            c_F3_B:  return {{24{v[7]}}, v[7:0]};
            c_F3_H:  return {{16{v[15]}}, v[15:0]};
            c_F3_BU: return {24'd0, v[7:0]};
            c_F3_HU: return {16'd0, v[15:0]};
            default: return v;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Bundle of the arbiter's requester buses (m0, m1) and its
//               memory-side bus.
//               slave  - view taken by dmem_arbiter
//               master - view taken by the requesters and memory around it
// Ports       : mN_req/we/addr/wdata/func3 -> arbiter, mN_gnt/rvalid/rdata/err
//               <- arbiter, mem_en/we/addr/be/wdata <- arbiter, mem_rdata
//               -> arbiter
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    logic                 m0_req;
    logic                 m0_we;
    logic [AddrWidth-1:0] m0_addr;
    logic [DataWidth-1:0] m0_wdata;
    logic [2:0]           m0_func3;
    logic                 m0_gnt;
    logic                 m0_rvalid;
    logic [DataWidth-1:0] m0_rdata;
    logic                 m0_err;

    logic                 m1_req;
    logic                 m1_we;
    logic [AddrWidth-1:0] m1_addr;
    logic [DataWidth-1:0] m1_wdata;
    logic [2:0]           m1_func3;
    logic                 m1_gnt;
    logic                 m1_rvalid;
    logic [DataWidth-1:0] m1_rdata;
    logic                 m1_err;

    logic                 mem_en;
    logic                 mem_we;
    logic [AddrWidth-1:0] mem_addr;
    logic [3:0]           mem_be;
    logic [DataWidth-1:0] mem_wdata;
    logic [DataWidth-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_func3,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_func3,
        output m1_gnt, m1_rvalid, m1_rdata, m1_err,
        output mem_en, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_func3,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_func3,
        input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
        input  mem_en, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_lane_fmt.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane_fmt
// Description : Combinational byte-lane formatter. It steers store data onto
//               the addressed lanes, generates the byte enables, and extracts
//               and extends load data from the memory word.
// Ports       : i_func3   - width code
//               i_off     - effective byte offset within the word
//               i_st_data - right-aligned store data
//               i_ld_raw  - memory read word
//               o_be      - byte enables
//               o_st_lane - lane-steered store data
//               o_ld_data - extended load data
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_fmt
    import dmem_arbiter_pkg::*;
(
    input  wire logic [2:0]  i_func3,
    input  wire logic [1:0]  i_off,
    input  wire logic [31:0] i_st_data,
    input  wire logic [31:0] i_ld_raw,
    output logic      [3:0]  o_be,
    output logic      [31:0] o_st_lane,
    output logic      [31:0] o_ld_data
);
    logic [4:0] w_shamt;

    assign w_shamt   = {i_off, 3'b000};
    assign o_be      = byte_en(i_func3, i_off);
    assign o_st_lane = i_st_data << w_shamt;
    assign o_ld_data = load_ext(i_func3, i_ld_raw >> w_shamt);
endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin arbiter that gives two requesters access to one
//               32-bit data memory. Each access takes three cycles: grant in
//               IDLE, memory strobe in ISSUE, and response in RESP.
// Ports       : clk, rst (synchronous, active high)
//               bus (dmem_arbiter_if.slave) - requester and memory buses
// Config      : DMEM_ARB_MISALIGN_TRAP_EN - when defined, a misaligned
//               halfword (offset 3) or word (offset != 0) is rejected with err.
//               When undefined, the access is aligned down and performed.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
) (
    input wire logic       clk,
    input wire logic       rst,
    dmem_arbiter_if.slave  bus
);
    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_prio;      // requester that wins a tie
    logic                 r_sel;       // requester owning the current access
    logic                 r_we;
    logic [AddrWidth-1:0] r_addr;
    logic [DataWidth-1:0] r_wdata;
    logic [2:0]           r_func3;

    logic                 w_any;
    logic                 w_sel;
    logic                 w_legal;
    logic [1:0]           w_off;
    logic [3:0]           w_be;
    logic [31:0]          w_st_lane;
    logic [31:0]          w_ld_data;
    logic [31:0]          w_rsp_data;

    assign w_any = bus.m0_req | bus.m1_req;
    assign w_sel = (bus.m0_req & bus.m1_req) ? r_prio : bus.m1_req;

`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    assign w_off   = r_addr[1:0];
    assign w_legal = f3_legal(r_func3, r_we)
                   && !(is_half(r_func3) && (r_addr[1:0] == 2'd3))
                   && !((r_func3 == c_F3_W) && (r_addr[1:0] != 2'd0));
`else
    // Misaligned accesses are aligned down to the nearest lane set that fits.
    always_comb begin
        w_off = r_addr[1:0];
        if (r_func3 == c_F3_W) begin
            w_off = 2'd0;
        end else if (is_half(r_func3) && (r_addr[1:0] == 2'd3)) begin
            w_off = 2'd2;
        end
    end
    assign w_legal = f3_legal(r_func3, r_we);
`endif

    dmem_lane_fmt u_lane_fmt (
        .i_func3   (r_func3),
        .i_off     (w_off),
        .i_st_data (r_wdata),
        .i_ld_raw  (bus.mem_rdata),
        .o_be      (w_be),
        .o_st_lane (w_st_lane),
        .o_ld_data (w_ld_data)
    );

    assign w_rsp_data = (w_legal && !r_we) ? w_ld_data : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_prio  <= 1'b0;
            r_sel   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_func3 <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && w_any) begin
                r_sel   <= w_sel;
                r_prio  <= ~w_sel;
                r_we    <= w_sel ? bus.m1_we    : bus.m0_we;
                r_addr  <= w_sel ? bus.m1_addr  : bus.m0_addr;
                r_wdata <= w_sel ? bus.m1_wdata : bus.m0_wdata;
                r_func3 <= w_sel ? bus.m1_func3 : bus.m0_func3;
            end
        end
    end

    // Next state and outputs. All outputs are forced to 0 while rst is high,
    // which also drops any response that is in flight.
    always_comb begin
        w_state_nxt   = r_state;
        bus.m0_gnt    = 1'b0;
        bus.m0_rvalid = 1'b0;
        bus.m0_rdata  = '0;
        bus.m0_err    = 1'b0;
        bus.m1_gnt    = 1'b0;
        bus.m1_rvalid = 1'b0;
        bus.m1_rdata  = '0;
        bus.m1_err    = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_be    = 4'd0;
        bus.mem_wdata = '0;

        case (r_state)
            ST_IDLE:  if (w_any) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_RESP;
            default:  w_state_nxt = ST_IDLE;
        endcase

        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        bus.m0_gnt = ~w_sel;
                        bus.m1_gnt = w_sel;
                    end
                end
                ST_ISSUE: begin
                    if (w_legal) begin
                        bus.mem_en    = 1'b1;
                        bus.mem_we    = r_we;
                        bus.mem_addr  = {r_addr[AddrWidth-1:2], 2'b00};
                        bus.mem_be    = w_be;
                        bus.mem_wdata = w_st_lane;
                    end
                end
                ST_RESP: begin
                    if (r_sel) begin
                        bus.m1_rvalid = 1'b1;
                        bus.m1_rdata  = w_rsp_data;
                        bus.m1_err    = ~w_legal;
                    end else begin
                        bus.m0_rvalid = 1'b1;
                        bus.m0_rdata  = w_rsp_data;
                        bus.m0_err    = ~w_legal;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter. A cycle-level reference
//               model checks every output on every cycle. Directed
//               transactions pin the model with hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;

`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    localparam bit c_TRAP = 1'b1;
`else
    localparam bit c_TRAP = 1'b0;
`endif

    dmem_arbiter_if bus ();
    dmem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // ---------------- reference model (rules in plain arithmetic) ----------
    function automatic bit m_legal(input logic [2:0] f3, input bit we, input logic [1:0] off);
        bit ok;
        ok = (f3 <= 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
        if (c_TRAP && (f3 % 4 == 1) && off == 2'd3) ok = 1'b0;
        if (c_TRAP && f3 == 3'd2 && off != 2'd0) ok = 1'b0;
        return ok;
    endfunction

    function automatic int m_off(input logic [2:0] f3, input logic [1:0] off);
        int o;
        o = int'(off);
        if (!c_TRAP && f3 == 3'd2) o = 0;
        if (!c_TRAP && (f3 % 4 == 1) && o == 3) o = 2;
        return o;
    endfunction

    // Access size in bytes is 1, 2 or 4 for width codes mod 4 = 0, 1, 2.
    function automatic logic [3:0] m_be(input logic [2:0] f3, input int off);
        int nbytes;
        nbytes = 1 << (f3 % 4);
        return 4'(((1 << nbytes) - 1) << off);
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] rd, input int off);
        logic [31:0] v;
        longint      x;
        int          bits;
        v = rd >> (8 * off);
        if (f3 == 3'd2) return v;
        bits = (f3 % 4 == 0) ? 8 : 16;
        x = longint'(v) & ((64'sd1 <<< bits) - 1);
        if (f3 < 3'd4 && x >= (64'sd1 <<< (bits - 1))) x = x - (64'sd1 <<< bits);
        return 32'(x);
    endfunction

    int          m_age  = 0;   // cycles since the pending access was granted, 0 = free
    int          m_prio = 0;   // requester favoured when both ask
    int          m_who  = 0;
    bit          m_we   = 1'b0;
    logic [31:0] m_addr = 32'd0;
    logic [31:0] m_wdata = 32'd0;
    logic [2:0]  m_f3   = 3'd0;

    always @(negedge clk) begin
        logic [1:0]  eg;
        bit          lg;
        int          off;
        logic        e_en, e_we, e_rv, e_err;
        logic [31:0] e_addr, e_wd, e_rd;
        logic [3:0]  e_be;
        eg = 2'b00; e_en = 0; e_we = 0; e_rv = 0; e_err = 0;
        e_addr = 0; e_wd = 0; e_rd = 0; e_be = 0;
        lg  = m_legal(m_f3, m_we, m_addr[1:0]);
        off = m_off(m_f3, m_addr[1:0]);
        if (!rst) begin
            if (m_age == 0) begin
                if (bus.m0_req && bus.m1_req) eg = (m_prio == 0) ? 2'b01 : 2'b10;
                else eg = {bus.m1_req, bus.m0_req};
            end
            if (m_age == 1 && lg) begin
                e_en = 1; e_we = m_we; e_addr = m_addr & ~32'h3;
                e_be = m_be(m_f3, off); e_wd = m_wdata << (8 * off);
            end
            if (m_age == 2) begin
                e_rv = 1; e_err = !lg;
                e_rd = (lg && !m_we) ? m_load(m_f3, bus.mem_rdata, off) : 32'd0;
            end
        end
        chk("m0_gnt",    bus.m0_gnt,    eg[0]);
        chk("m1_gnt",    bus.m1_gnt,    eg[1]);
        chk("mem_en",    bus.mem_en,    e_en);
        chk("mem_we",    bus.mem_we,    e_we);
        chk("mem_addr",  bus.mem_addr,  e_addr);
        chk("mem_be",    bus.mem_be,    e_be);
        chk("mem_wdata", bus.mem_wdata, e_wd);
        chk("m0_rvalid", bus.m0_rvalid, e_rv && m_who == 0);
        chk("m0_rdata",  bus.m0_rdata,  (m_who == 0) ? e_rd : 32'd0);
        chk("m0_err",    bus.m0_err,    e_err && m_who == 0);
        chk("m1_rvalid", bus.m1_rvalid, e_rv && m_who == 1);
        chk("m1_rdata",  bus.m1_rdata,  (m_who == 1) ? e_rd : 32'd0);
        chk("m1_err",    bus.m1_err,    e_err && m_who == 1);
        if (rst) begin
            m_age = 0; m_prio = 0; m_who = 0; m_we = 0;
            m_addr = 0; m_wdata = 0; m_f3 = 0;
        end else if (m_age != 0) begin
            m_age = (m_age + 1) % 3;
        end else if (eg != 2'b00) begin
            m_who   = eg[1] ? 1 : 0;
            m_we    = (m_who == 1) ? bus.m1_we    : bus.m0_we;
            m_addr  = (m_who == 1) ? bus.m1_addr  : bus.m0_addr;
            m_wdata = (m_who == 1) ? bus.m1_wdata : bus.m0_wdata;
            m_f3    = (m_who == 1) ? bus.m1_func3 : bus.m0_func3;
            m_prio  = 1 - m_who;
            m_age   = 1;
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    typedef struct {
        int          waits;
        logic        gnt, en, we, rv, err;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  be;
    } obs_t;

    task automatic set_req(input int who, input bit r, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] f3);
        if (who == 0) begin
            bus.m0_req = r; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_func3 = f3;
        end else begin
            bus.m1_req = r; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_func3 = f3;
        end
    endtask

    function automatic logic gnt_of(input int who);
        return (who == 0) ? bus.m0_gnt : bus.m1_gnt;
    endfunction

    // Waits (bounded) for the grant, drops the request after it, returns the cycle.
    task automatic wait_gnt(input int who, output int at);
        at = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gnt_of(who)) begin
                at = cyc;
                break;
            end
        end
        chk($sformatf("m%0d_gnt_seen", who), 32'(at >= 0), 32'd1);
        if (at >= 0) begin
            @(posedge clk); #1;
            set_req(who, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        end
    endtask

    task automatic txn(input int who, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, input logic [31:0] rd, output obs_t o);
        o = '{default: 0};
        @(posedge clk); #1;
        bus.mem_rdata = rd;
        set_req(who, 1'b1, we, addr, wdata, f3);
        for (int i = 0; i < 8 && !o.gnt; i++) begin
            @(negedge clk);
            o.waits++;
            o.gnt = gnt_of(who);
        end
        if (!o.gnt) begin
            chk("txn_gnt_timeout", 32'(o.gnt), 32'd1);
            set_req(who, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
            return;
        end
        @(posedge clk); #1;
        set_req(who, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        @(negedge clk);
        o.en = bus.mem_en; o.we = bus.mem_we; o.addr = bus.mem_addr;
        o.be = bus.mem_be; o.wdata = bus.mem_wdata;
        @(negedge clk);
        o.rv    = (who == 0) ? bus.m0_rvalid : bus.m1_rvalid;
        o.rdata = (who == 0) ? bus.m0_rdata  : bus.m1_rdata;
        o.err   = (who == 0) ? bus.m0_err    : bus.m1_err;
    endtask

    // ---------------- directed sequence ----------------------------------
    initial begin
        obs_t o;
        int   t0, t1;
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        bus.mem_rdata = 32'd0;
        rst = 1'b1;
        bus.m0_req = 1'b1;                   // request held during reset is ignored
        repeat (3) @(negedge clk);
        chk("rst_m0_gnt", bus.m0_gnt, 32'd0);
        chk("rst_mem_en", bus.mem_en, 32'd0);
        @(posedge clk); #1;
        bus.m0_req = 1'b0;
        rst = 1'b0;

        // simultaneous requests from reset: m0 then m1, twice
        for (int rep = 0; rep < 2; rep++) begin
            @(posedge clk); #1;
            set_req(0, 1'b1, 1'b0, 32'h10, 32'd0, 3'd2);
            set_req(1, 1'b1, 1'b0, 32'h14, 32'd0, 3'd2);
            wait_gnt(0, t0);
            wait_gnt(1, t1);
            chk($sformatf("pair%0d_m1_after_m0", rep), 32'(t1 - t0), 32'd3);
            @(negedge clk); @(negedge clk);
        end

        // sw m0 0x100
        txn(0, 1'b1, 32'h100, 32'hDEADBEEF, 3'd2, 32'd0, o);
        chk("sw_gnt_first_cycle", 32'(o.waits), 32'd1);
        chk("sw_mem_en", o.en, 32'd1);
        chk("sw_mem_we", o.we, 32'd1);
        chk("sw_mem_be", o.be, 32'hF);
        chk("sw_mem_addr", o.addr, 32'h100);
        chk("sw_mem_wdata", o.wdata, 32'hDEADBEEF);
        chk("sw_rvalid", o.rv, 32'd1);
        chk("sw_err", o.err, 32'd0);
        chk("sw_rdata", o.rdata, 32'd0);

        // lb / lbu m1 0x103
        txn(1, 1'b0, 32'h103, 32'd0, 3'd0, 32'h80112233, o);
        chk("lb_mem_be", o.be, 32'h8);
        chk("lb_mem_addr", o.addr, 32'h100);
        chk("lb_rdata", o.rdata, 32'hFFFFFF80);
        txn(1, 1'b0, 32'h103, 32'd0, 3'd4, 32'h80112233, o);
        chk("lbu_rdata", o.rdata, 32'h00000080);

        // lh / lhu m0 0x202
        txn(0, 1'b0, 32'h202, 32'd0, 3'd1, 32'h80011234, o);
        chk("lh_mem_be", o.be, 32'hC);
        chk("lh_rdata", o.rdata, 32'hFFFF8001);
        txn(0, 1'b0, 32'h202, 32'd0, 3'd5, 32'h80011234, o);
        chk("lhu_rdata", o.rdata, 32'h00008001);

        // sb m1 0x101
        txn(1, 1'b1, 32'h101, 32'h000000A5, 3'd0, 32'd0, o);
        chk("sb_mem_be", o.be, 32'h2);
        chk("sb_mem_wdata", o.wdata, 32'h0000A500);

        // sh m0 0x203 (misaligned halfword)
        txn(0, 1'b1, 32'h203, 32'h0000ABCD, 3'd1, 32'd0, o);
        if (c_TRAP) begin
            chk("sh3_mem_en", o.en, 32'd0);
            chk("sh3_err", o.err, 32'd1);
            chk("sh3_rdata", o.rdata, 32'd0);
        end else begin
            chk("sh3_mem_be", o.be, 32'hC);
            chk("sh3_mem_addr", o.addr, 32'h200);
            chk("sh3_mem_wdata", o.wdata, 32'hABCD0000);
            chk("sh3_err", o.err, 32'd0);
        end

        // lw m0 0x106 (misaligned word)
        txn(0, 1'b0, 32'h106, 32'd0, 3'd2, 32'hCAFEF00D, o);
        if (c_TRAP) begin
            chk("lw6_mem_en", o.en, 32'd0);
            chk("lw6_err", o.err, 32'd1);
        end else begin
            chk("lw6_mem_addr", o.addr, 32'h104);
            chk("lw6_mem_be", o.be, 32'hF);
            chk("lw6_rdata", o.rdata, 32'hCAFEF00D);
        end

        // illegal width codes
        txn(1, 1'b0, 32'h40, 32'd0, 3'd3, 32'h5555AAAA, o);
        chk("f3_3_mem_en", o.en, 32'd0);
        chk("f3_3_rvalid", o.rv, 32'd1);
        chk("f3_3_err", o.err, 32'd1);
        chk("f3_3_rdata", o.rdata, 32'd0);
        txn(0, 1'b1, 32'h44, 32'h1234, 3'd5, 32'd0, o);
        chk("shu_mem_en", o.en, 32'd0);
        chk("shu_err", o.err, 32'd1);

        // reset during ISSUE of an m1 lw
        @(posedge clk); #1;
        bus.mem_rdata = 32'h11223344;
        set_req(1, 1'b1, 1'b0, 32'h300, 32'd0, 3'd2);
        wait_gnt(1, t0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_issue_mem_en", bus.mem_en, 32'd0);
        chk("rst_issue_m1_rvalid", bus.m1_rvalid, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_m1_rvalid", bus.m1_rvalid, 32'd0);
        chk("post_rst_mem_en", bus.mem_en, 32'd0);
        txn(0, 1'b0, 32'h300, 32'd0, 3'd2, 32'h0BADF00D, o);
        chk("post_rst_m0_gnt_first_cycle", 32'(o.waits), 32'd1);
        chk("post_rst_m0_rdata", o.rdata, 32'h0BADF00D);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: AddrWidth, default 32, byte-address width.
REQ-002 Parameter: DataWidth, default 32, data word width; only 32 is supported.
REQ-003 Port: clk, input, 1, single clock; all state changes on the rising edge.
REQ-004 Port: rst, input, 1, synchronous active-high reset.
REQ-005 Ports, requester mN where N = 0, 1, all inputs:
- mN_req, 1: request
- mN_we, 1: store when 1
- mN_addr, AddrWidth: byte address
- mN_wdata, DataWidth: store data, right-aligned
- mN_func3, 3: RISC-V width code
REQ-006 Ports, requester mN, all outputs:
- mN_gnt, 1: request accepted this cycle
- mN_rvalid, 1: response valid
- mN_rdata, DataWidth: extended load data
- mN_err, 1: access rejected
REQ-007 Ports, memory side:
- mem_en, output, 1: access strobe
- mem_we, output, 1: write strobe
- mem_addr, output, AddrWidth: word-aligned address, low 2 bits 0
- mem_be, output, 4: byte enables
- mem_wdata, output, DataWidth: lane-steered store data
- mem_rdata, input, DataWidth: read data, valid one cycle after mem_en

Function
REQ-008 FSM states SHALL be IDLE, ISSUE and RESP; transitions IDLE->ISSUE on grant, ISSUE->RESP always, RESP->IDLE always.
REQ-009 In IDLE with any mN_req high, the block SHALL assert exactly one mN_gnt combinationally in that cycle and latch that requester's we/addr/wdata/func3 at the clock edge.
REQ-010 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not granted last; with one request, grant it.
REQ-011 The grant pointer SHALL update only on a grant.
REQ-012 Requesters SHALL hold req and command stable until gnt; no gnt SHALL be asserted outside IDLE.
REQ-013 In ISSUE, mem_en SHALL be 1 and mem_we/mem_addr/mem_be/mem_wdata SHALL be driven from the latched command; all mem_* SHALL be 0 in every other state.
REQ-014 Byte enables by offset off = addr[1:0]:
- func3 0 (sb): be = 0001<<off
- func3 1 (sh): be = 0011<<off
- func3 2 (sw): be = 1111
REQ-015 Store data SHALL be steered by shifting left 8*off bits.
REQ-016 In RESP, rvalid SHALL be 1 for exactly one cycle on the granted requester only.
REQ-017 Load data in RESP SHALL be mem_rdata shifted right by 8*off:
- func3 0 (lb): sign-extended from bit 7
- func3 1 (lh): sign-extended from bit 15
- func3 4 (lbu): zero-extended from bit 7
- func3 5 (lhu): zero-extended from bit 15
- func3 2 (lw): unmodified
REQ-018 Stores SHALL respond with rdata = 0 and err = 0.
REQ-019 Illegal func3 (3, 6, 7, or 4/5 with we = 1) SHALL suppress mem_en in ISSUE and respond in RESP with err = 1, rdata = 0.
REQ-020 Latency from gnt to rvalid SHALL be exactly 2 cycles; maximum throughput is one access per 3 cycles.
REQ-021 rdata and err SHALL be 0 on any requester whose rvalid is 0.

Reset
REQ-022 On rst, state SHALL go to IDLE, the pointer SHALL favour m0, and the latched command SHALL be cleared.
REQ-023 While rst is high, all outputs SHALL be 0.
REQ-024 Reset in ISSUE or RESP SHALL abandon the transaction with no rvalid; the store already issued in ISSUE is not undone.

Configuration
REQ-025 Macro DMEM_ARB_MISALIGN_TRAP_EN SHALL select misalignment handling.
REQ-026 With DMEM_ARB_MISALIGN_TRAP_EN defined, halfword at off = 3 or word at off != 0 SHALL be rejected as in REQ-019 (no mem_en, err = 1).
REQ-027 Without DMEM_ARB_MISALIGN_TRAP_EN, a misaligned access SHALL be aligned down (halfword off 3 -> 2, word -> 0) and performed with err = 0.

Structure
REQ-028 A shared package SHALL hold the func3 encoding constants, the FSM state enum and a byte-enable/extension helper function.
REQ-029 One sub-module, dmem_lane_fmt, SHALL be instantiated: combinational store steering plus load extraction and extension.

Verification
REQ-030 m0 sw addr 0x100, wdata 0xDEADBEEF -> m0_gnt in T0; ISSUE: mem_be = 1111, mem_addr = 0x100; m0_rvalid at T0+2, err = 0.
REQ-031 m1 lb addr 0x103, mem_rdata 0x80112233 -> m1_rdata = 0xFFFFFF80; lbu on the same data -> 0x00000080.
REQ-032 m0 and m1 request together from reset -> m0 granted first, m1 granted in the next IDLE; repeat the pair -> m0 then m1 again.
REQ-033 m0 sh addr 0x203, trap macro defined -> no mem_en, err = 1, rdata = 0; macro undefined -> mem_be = 1100, mem_addr = 0x200.
REQ-034 rst asserted during ISSUE of m1 lw -> no m1_rvalid; next cycle all outputs 0; a following m0 request is granted in IDLE.
REQ-035 func3 = 3 load from m1 -> mem_en stays 0 for the whole transaction, m1_err = 1 at T0+2.
